// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame widths and the
// parity rule used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 7;
    localparam int unsigned UART_FRAME_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    // Parity bit carried on the line: makes the 8-bit {P, data} word odd.
    function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Serial-side inputs and character-side outputs of the UART receiver.
interface uart_receiver_if;
    import uart_pkg::*;

    logic                   rx;
    logic                   rx_en;
    logic [UART_DATA_W-1:0] data_out;
    logic                   valid;
    logic                   parity_err;
    logic                   frame_err;
    logic                   busy;

    modport master (
        output rx,
        output rx_en,
        input  data_out,
        input  valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        input  rx_en,
        output data_out,
        output valid,
        output parity_err,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin, plus one delay flop
// so the FSM can see falling edges. All flops reset to the idle level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic rx_d
);

    logic rx_meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start-edge detect, mid-bit sampling of parity + 7 data bits
// (MSB first) and stop bit, then a one-cycle valid with error flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_receiver_if.slave  bus
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = 3;

    uart_state_e                state;
    logic [TICK_W-1:0]          tick_cnt;
    logic [BIT_W-1:0]           bit_cnt;
    logic [UART_FRAME_BITS-1:0] shift;
    logic [UART_DATA_W-1:0]     data_q;
    logic                       valid_q;
    logic                       parity_err_q;
    logic                       frame_err_q;
    logic                       busy_q;
    logic                       rx_s;
    logic                       rx_d;
    logic                       tick_half;
    logic                       tick_last;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (bus.rx),
        .rx_s  (rx_s),
        .rx_d  (rx_d)
    );

    assign tick_half = (tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1));
    assign tick_last = (tick_cnt == TICK_W'(OVERSAMPLE - 1));

    // Receive FSM; rx_en gates every counter, edge detection runs every clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s && rx_d) begin
                        state    <= START;
                        tick_cnt <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    if (bus.rx_en) begin
                        if (tick_half) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            if (rx_s) begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (bus.rx_en) begin
                        if (tick_last) begin
                            tick_cnt <= '0;
                            shift    <= {shift[UART_FRAME_BITS-2:0], rx_s};
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_W'(UART_FRAME_BITS - 1)) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (bus.rx_en) begin
                        if (tick_last) begin
                            tick_cnt     <= '0;
                            data_q       <= shift[UART_DATA_W-1:0];
                            parity_err_q <= (shift[UART_FRAME_BITS-1] !=
                                             uart_parity(shift[UART_DATA_W-1:0]));
                            frame_err_q  <= ~rx_s;
                            valid_q      <= 1'b1;
                            busy_q       <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: hand-built frames with hand-computed
// parity and expected outputs, logged per valid pulse.
module tb_uart_receiver;

    localparam int unsigned OS       = 16;
    localparam int unsigned EN_DIV   = 4;
    localparam int unsigned BIT_CLKS = OS * EN_DIV;

    logic clk = 1'b0;
    logic reset;

    uart_receiver_if bus ();

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] log_data[$];
    logic       log_perr[$];
    logic       log_ferr[$];

    // rx_en: one-clk tick every EN_DIV clocks
    initial begin : en_gen
        int unsigned cnt;
        cnt = 0;
        bus.rx_en = 1'b0;
        forever begin
            @(negedge clk);
            bus.rx_en = (cnt == EN_DIV - 1);
            cnt = (cnt + 1) % EN_DIV;
        end
    end

    // One log entry per clk that valid is high
    always @(negedge clk) begin
        if (bus.valid) begin
            log_data.push_back(bus.data_out);
            log_perr.push_back(bus.parity_err);
            log_ferr.push_back(bus.frame_err);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.rx = b;
        wait_clks(BIT_CLKS);
    endtask

    // Line order: start, parity, d6..d0, stop; line is left at the stop level
    task automatic send_frame(input logic [6:0] d, input logic p, input logic stop);
        send_bit(1'b0);
        send_bit(p);
        for (int i = 6; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic check_outputs(input string tag, input logic [6:0] d,
                                 input logic perr, input logic ferr);
        check({tag, "_data"}, 32'(bus.data_out), 32'(d));
        check({tag, "_perr"}, 32'(bus.parity_err), 32'(perr));
        check({tag, "_ferr"}, 32'(bus.frame_err), 32'(ferr));
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int base;
        reset  = 1'b1;
        bus.rx = 1'b1;
        wait_clks(5);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check_outputs("rst", 7'h00, 1'b0, 1'b0);
        reset = 1'b0;
        wait_clks(10);

        // Good frame 0x41, P=1
        base = log_data.size();
        send_frame(7'h41, 1'b1, 1'b1);
        wait_clks(40);
        check("good_cnt", 32'(log_data.size() - base), 32'd1);
        check_outputs("good", 7'h41, 1'b0, 1'b0);

        // Parity error: 0x41 with P forced to 0
        base = log_data.size();
        send_frame(7'h41, 1'b0, 1'b1);
        wait_clks(40);
        check("par_cnt", 32'(log_data.size() - base), 32'd1);
        check_outputs("par", 7'h41, 1'b1, 1'b0);

        // Framing error: 0x7F (P=0), stop 0, line held low for two frames
        base = log_data.size();
        send_frame(7'h7F, 1'b0, 1'b0);
        bus.rx = 1'b0;
        wait_clks(2 * 10 * BIT_CLKS);
        check("frm_cnt", 32'(log_data.size() - base), 32'd1);
        check_outputs("frm", 7'h7F, 1'b0, 1'b1);
        bus.rx = 1'b1;
        wait_clks(BIT_CLKS);

        // Recovery: 0x55 (four ones, P=1)
        base = log_data.size();
        send_frame(7'h55, 1'b1, 1'b1);
        wait_clks(40);
        check("rec_cnt", 32'(log_data.size() - base), 32'd1);
        check_outputs("rec", 7'h55, 1'b0, 1'b0);

        // Glitch: low for 4 rx_en ticks, then high again
        base = log_data.size();
        bus.rx = 1'b0;
        wait_clks(8);
        check("glitch_busy_hi", 32'(bus.busy), 32'd1);
        wait_clks(4 * EN_DIV - 8);
        bus.rx = 1'b1;
        wait_clks(100);
        check("glitch_busy_lo", 32'(bus.busy), 32'd0);
        check("glitch_cnt", 32'(log_data.size() - base), 32'd0);
        check("glitch_data", 32'(bus.data_out), 32'h55);

        // Back-to-back: 0x41 (P=1) then 0x7F (P=0), no idle gap
        base = log_data.size();
        send_frame(7'h41, 1'b1, 1'b1);
        send_frame(7'h7F, 1'b0, 1'b1);
        wait_clks(40);
        check("b2b_cnt", 32'(log_data.size() - base), 32'd2);
        if (log_data.size() >= base + 2) begin
            check("b2b0_data", 32'(log_data[base]), 32'h41);
            check("b2b0_perr", 32'(log_perr[base]), 32'd0);
            check("b2b0_ferr", 32'(log_ferr[base]), 32'd0);
            check("b2b1_data", 32'(log_data[base+1]), 32'h7F);
            check("b2b1_perr", 32'(log_perr[base+1]), 32'd0);
            check("b2b1_ferr", 32'(log_ferr[base+1]), 32'd0);
        end

        // Reset during DATA after d6,d5,d4 of 0x41
        base = log_data.size();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        wait_clks(10);
        check("mid_busy", 32'(bus.busy), 32'd1);
        reset  = 1'b1;
        bus.rx = 1'b1;
        wait_clks(3);
        check("mrst_valid", 32'(bus.valid), 32'd0);
        check_outputs("mrst", 7'h00, 1'b0, 1'b0);
        reset = 1'b0;
        wait_clks(100);
        check("mrst_cnt", 32'(log_data.size() - base), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);

        // 0x2A (three ones, P=0) after the aborted frame
        base = log_data.size();
        send_frame(7'h2A, 1'b0, 1'b1);
        wait_clks(40);
        check("post_cnt", 32'(log_data.size() - base), 32'd1);
        check_outputs("post", 7'h2A, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
